// File: rtl/spi_xfer_ctrl.sv
// Multi-byte SPI transaction sequencer: asserts a slave select with setup/hold
// gaps around a burst of bytes fed one at a time to the spi byte engine.
module spi_xfer_ctrl #(
  parameter int unsigned N_SS     = 4,
  parameter int unsigned SS_W     = 2,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [SS_W-1:0] cmd_ss,
  input  logic [7:0]      cmd_len,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  output logic            busy,
  output logic            done,
  output logic [N_SS-1:0] ss_n,
  output logic [7:0]      spi_din,
  output logic            spi_start,
  input  logic            spi_ready,
  input  logic            spi_done_tick,
  input  logic [7:0]      spi_dout
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned REM_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    XFER,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [REM_W-1:0] remaining_q, remaining_d;
  logic [N_SS-1:0]  ss_n_q, ss_n_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [N_SS-1:0]  ss_sel_n;
  logic             byte_go;

  // Out-of-range slave index leaves every select high (dummy-clock transfer)
  always_comb begin
    ss_sel_n = '1;
    for (int unsigned i = 0; i < N_SS; i++) begin
      if (32'(cmd_ss) == i) ss_sel_n[i] = 1'b0;
    end
  end

  assign byte_go   = reset && (state_q == LOAD) && tx_valid && spi_ready;
  assign tx_ready  = byte_go;
  assign spi_start = byte_go;
  assign spi_din   = byte_go ? tx_data : 8'h00;

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    remaining_d = remaining_q;
    ss_n_d      = ss_n_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          ss_n_d      = ss_sel_n;
          remaining_d = (cmd_len == 8'd0) ? REM_W'(256) : REM_W'(cmd_len);
          gap_d       = CNT_W'(CS_SETUP - 1);
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (gap_q == '0) state_d = LOAD;
        else             gap_d   = gap_q - CNT_W'(1);
      end
      LOAD: begin
        if (byte_go) begin
          remaining_d = remaining_q - REM_W'(1);
          state_d     = XFER;
        end
      end
      XFER: begin
        if (spi_done_tick) begin
          rx_data_d  = spi_dout;
          rx_valid_d = 1'b1;
          if (remaining_q == '0) begin
            gap_d   = CNT_W'(CS_HOLD - 1);
            state_d = HOLD;
          end else begin
            state_d = LOAD;
          end
        end
      end
      HOLD: begin
        // Gap expires, then one cycle with done high before selects release
        if (gap_q != '0) begin
          gap_d = gap_q - CNT_W'(1);
        end else if (!done_q) begin
          done_d = 1'b1;
        end else begin
          ss_n_d  = '1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      remaining_q <= '0;
      ss_n_q      <= '1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      remaining_q <= remaining_d;
      ss_n_q      <= ss_n_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ss_n      = ss_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl with a behavioural spi byte-engine stub
// running in loopback (each byte sent comes back as the received byte).
module tb_spi_xfer_ctrl;

  localparam int unsigned N_SS     = 4;
  localparam int unsigned SS_W     = 3;
  localparam int unsigned CS_SETUP = 3;
  localparam int unsigned CS_HOLD  = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [SS_W-1:0] cmd_ss;
  logic [7:0]      cmd_len;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            busy;
  logic            done;
  logic [N_SS-1:0] ss_n;
  logic [7:0]      spi_din;
  logic            spi_start;
  logic            spi_ready;
  logic            spi_done_tick;
  logic [7:0]      spi_dout = 8'h00;

  logic            tick_q;
  logic            stray_tick;
  logic [7:0]      sh_q;
  int              lat_q;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [N_SS-1:0] ss;
    int              nbytes;
  } cmd_t;

  cmd_t       exp_cmd[$];
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];

  spi_xfer_ctrl #(
    .N_SS(N_SS), .SS_W(SS_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ss(cmd_ss), .cmd_len(cmd_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .ss_n(ss_n),
    .spi_din(spi_din), .spi_start(spi_start), .spi_ready(spi_ready),
    .spi_done_tick(spi_done_tick), .spi_dout(spi_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
  endfunction

  // spi byte-engine stub: random 2..6 cycle byte time, loopback data, shares reset
  always @(posedge clk) begin
    if (!reset) begin
      spi_ready <= 1'b1;
      tick_q    <= 1'b0;
      lat_q     <= 0;
    end else begin
      tick_q <= 1'b0;
      if (spi_ready && spi_start) begin
        spi_ready <= 1'b0;
        lat_q     <= int'($urandom_range(6, 2));
        sh_q      <= spi_din;
      end else if (!spi_ready) begin
        if (lat_q <= 1) begin
          tick_q    <= 1'b1;
          spi_ready <= 1'b1;
          spi_dout  <= sh_q;
        end else begin
          lat_q <= lat_q - 1;
        end
      end
    end
  end

  assign spi_done_tick = tick_q | stray_tick;

  // Monitor: per-transaction timing, select pattern, byte count and rx stream
  bit              mon_active = 1'b0;
  bit              post_done  = 1'b0;
  int              t_acc, starts, last_tick, ss_bad, cur_n;
  logic [N_SS-1:0] cur_ss;

  always @(negedge clk) begin
    cmd_t c;
    if (!reset) begin
      mon_active = 1'b0;
      post_done  = 1'b0;
    end else begin
      if (post_done) begin
        check("ss_release", 32'(ss_n), 32'(4'hF));
        check("ready_after_done", 32'(cmd_ready), 32'd1);
        post_done = 1'b0;
      end
      if (mon_active) begin
        if (ss_n !== cur_ss || busy !== 1'b1) ss_bad++;
        if (spi_start) begin
          starts++;
          if (starts == 1) check("setup_gap", 32'(cyc - t_acc), 32'(CS_SETUP + 1));
        end
        if (tick_q) last_tick = cyc;
        if (done) begin
          check("hold_gap", 32'(cyc - last_tick), 32'(CS_HOLD + 1));
          check("start_count", 32'(starts), 32'(cur_n));
          check("ss_hold_bad_cycles", 32'(ss_bad), 32'd0);
          mon_active = 1'b0;
          post_done  = 1'b1;
        end
      end else if (done) begin
        check("spurious_done", 32'(done), 32'd0);
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          fail_now("unexpected_accept");
        end else begin
          c          = exp_cmd.pop_front();
          cur_ss     = c.ss;
          cur_n      = c.nbytes;
          mon_active = 1'b1;
          t_acc      = cyc;
          starts     = 0;
          ss_bad     = 0;
          last_tick  = cyc;
        end
      end
      if (rx_valid) begin
        if (exp_rx.size() == 0) fail_now("spurious_rx_valid");
        else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int ss, input int len, input bit hold_valid, input int alt_ss);
    cmd_t c;
    bit   got = 1'b0;
    c.ss = '1;
    if (ss < int'(N_SS)) c.ss[ss] = 1'b0;
    c.nbytes = (len == 0) ? 256 : len;
    exp_cmd.push_back(c);
    cmd_valid = 1'b1;
    cmd_ss    = SS_W'(ss);
    cmd_len   = 8'(len);
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge clk);
      got = cmd_ready;
      step();
    end
    if (!got) fail_now("cmd_accept_timeout");
    if (hold_valid && got) cmd_ss = SS_W'(alt_ss);
    else cmd_valid = 1'b0;
  endtask

  task automatic send_bytes(input int stall_idx, input int stall_cyc, input int stop_after);
    bit got;
    bit abort = 1'b0;
    foreach (tx_q[i]) exp_rx.push_back(tx_q[i]);
    for (int i = 0; i < tx_q.size() && i < stop_after && !abort; i++) begin
      if (i == stall_idx) begin
        tx_valid = 1'b0;
        repeat (stall_cyc) step();
      end
      tx_data  = tx_q[i];
      tx_valid = 1'b1;
      got      = 1'b0;
      for (int w = 0; w < 2000 && !got; w++) begin
        @(negedge clk);
        got = tx_ready;
        step();
      end
      if (!got) begin
        fail_now("tx_consume_timeout");
        abort = 1'b1;
      end
    end
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int w = 0; w < 3000 && !got; w++) begin
      @(negedge clk);
      got = cmd_ready && !busy && !mon_active && !post_done;
      step();
    end
    if (!got) fail_now("idle_timeout");
  endtask

  task automatic fill_rand(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  initial begin
    bit got;
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_ss     = '0;
    cmd_len    = '0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    stray_tick = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    @(negedge clk);
    check("rst_ss_n", 32'(ss_n), 32'(4'hF));
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    step();

    // Single byte to slave 2
    issue(2, 1, 1'b0, 0);
    tx_q.delete();
    tx_q.push_back(8'hA5);
    send_bytes(-1, 0, 1000);
    wait_idle();

    // Four bytes with a 20-cycle tx stall before byte 3
    issue(int'($urandom_range(3, 0)), 4, 1'b0, 0);
    tx_q.delete();
    for (int i = 1; i <= 4; i++) tx_q.push_back(8'(i));
    send_bytes(2, 20, 1000);
    wait_idle();

    // len=0 means 256 bytes
    issue(1, 0, 1'b0, 0);
    tx_q.delete();
    for (int i = 0; i < 256; i++) tx_q.push_back(8'(i));
    send_bytes(-1, 0, 1000);
    wait_idle();

    // Out-of-range slave index: dummy-clock transfer, selects stay high
    issue(5, 1, 1'b0, 0);
    fill_rand(1);
    send_bytes(-1, 0, 1000);
    wait_idle();

    // Reset during byte 2 of 3, then a normal command
    issue(1, 3, 1'b0, 0);
    fill_rand(3);
    send_bytes(-1, 0, 2);
    reset = 1'b0;
    exp_rx.delete();
    exp_cmd.delete();
    step();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ss_n", 32'(ss_n), 32'(4'hF));
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    step();
    issue(3, 2, 1'b0, 0);
    fill_rand(2);
    send_bytes(-1, 0, 1000);
    wait_idle();

    // cmd_valid held high with another slave index while busy
    issue(0, 3, 1'b1, 2);
    fill_rand(3);
    send_bytes(-1, 0, 1000);
    got = 1'b0;
    for (int w = 0; w < 500 && !got; w++) begin
      @(negedge clk);
      got = done;
      step();
    end
    if (!got) fail_now("held_valid_done_timeout");
    cmd_valid = 1'b0;
    wait_idle();

    // Random transactions, some with a stray done tick during the setup gap
    for (int t = 0; t < 10; t++) begin
      int len;
      len = int'($urandom_range(12, 1));
      issue(int'($urandom_range(7, 0)), len, 1'b0, 0);
      if ($urandom_range(1, 0) == 1) begin
        step();
        stray_tick = 1'b1;
        step();
        stray_tick = 1'b0;
      end
      fill_rand(len);
      send_bytes(int'($urandom_range(len, 0)), int'($urandom_range(5, 0)), 1000);
      wait_idle();
    end

    repeat (5) step();
    check("exp_cmd_drained", 32'(exp_cmd.size()), 32'd0);
    check("exp_rx_drained", 32'(exp_rx.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
